// File: rtl/eb_fifo.sv
// eb_fifo: DEPTH-entry valid/ready elastic buffer with registered t_ready and occupancy output.
// Optional zero-latency cut-through when empty: define EB_FIFO_BYPASS_EN.
module eb_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [CW-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign t_ready = (r_count != FULL_CNT);
    assign count   = r_count;

`ifdef EB_FIFO_BYPASS_EN
    logic w_cut;
    logic w_cut_through;

    // Cut-through is gated by rstf so nothing is presented while reset is held.
    assign w_cut         = w_empty & t_valid & rstf;
    assign w_cut_through = w_cut & i_ready;

    always_comb begin
        i_valid = ~w_empty | w_cut;
        i_data  = w_cut ? t_data : r_mem[r_rd_ptr];
        w_push  = t_valid & t_ready & ~w_cut_through;
        w_pop   = ~w_empty & i_ready;
    end
`else
    always_comb begin
        i_valid = ~w_empty;
        i_data  = r_mem[r_rd_ptr];
        w_push  = t_valid & t_ready;
        w_pop   = i_valid & i_ready;
    end
`endif

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= t_data;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eb_fifo.sv
// Self-checking bench for eb_fifo (DWIDTH=8, DEPTH=4): reference count model plus data scoreboard queue.
module tb_eb_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);
`ifdef EB_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstf;
    logic [DW-1:0] t_data;
    logic          t_valid;
    logic          t_ready;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
    logic [CW-1:0] count;

    eb_fifo #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk     (clk),
        .rstf    (rstf),
        .t_data  (t_data),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [DW-1:0] sb_q[$];
    int unsigned   m_count = 0;
    int unsigned   n_out   = 0;
    bit            last_push = 1'b0;
    bit            watch_first = 1'b0;
    logic [DW-1:0] first_out = '0;
    bit            got_first = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model is evaluated mid-cycle and represents what the next rising edge will do.
    always @(negedge clk) begin
        bit push, pop, exp_iv;
        last_push = 1'b0;
        if (!rstf) begin
            check("rst_count", 32'(count), 0);
            check("rst_tready", 32'(t_ready), 1);
            check("rst_ivalid", 32'(i_valid), 0);
            check("rst_idata", 32'(i_data), 0);
            sb_q.delete();
            m_count = 0;
        end else begin
            exp_iv = (m_count != 0) || (BYP && t_valid);
            check("count", 32'(count), m_count);
            check("t_ready", 32'(t_ready), 32'(m_count != DP));
            check("i_valid", 32'(i_valid), 32'(exp_iv));
            push = t_valid && (m_count != DP);
            pop  = i_ready && exp_iv;
            if (push) sb_q.push_back(t_data);
            if (exp_iv) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("i_data", 32'(i_data), 32'(sb_q[0]));
                end
            end
            if (pop && sb_q.size() != 0) begin
                if (watch_first && !got_first) begin
                    first_out = sb_q[0];
                    got_first = 1'b1;
                end
                void'(sb_q.pop_front());
                n_out++;
            end
            if (push && !pop) m_count++;
            else if (pop && !push) m_count--;
            last_push = push;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit done = 1'b0;
        t_valid = 1'b1;
        t_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            done = last_push;
        end
        if (!done) check("send_timeout", 0, 1);
        t_valid = 1'b0;
    endtask

    task automatic drain;
        i_ready = 1'b1;
        for (int i = 0; i < 50 && m_count != 0; i++) step(1);
        check("drained", m_count, 0);
    endtask

    initial begin
        rstf    = 1'b0;
        t_valid = 1'b1;
        t_data  = 8'hAA;
        i_ready = 1'b0;
        step(3);
        rstf    = 1'b1;
        t_valid = 1'b0;
        step(2);
        check("no_capture_in_reset", m_count, 0);
        check("no_capture_count", 32'(count), 0);

        // Streaming
        i_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            t_valid = 1'b1;
            t_data  = DW'(v);
            step(1);
        end
        t_valid = 1'b0;
        step(3);
        check("stream_out", n_out, 16);

        // Fill to full, fifth beat stalls
        i_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("full_count", 32'(count), 4);
        t_valid = 1'b1;
        t_data  = 8'h55;
        step(3);
        check("full_tready", 32'(t_ready), 0);
        check("full_head", 32'(i_data), 8'h11);

        // Drain from full
        i_ready = 1'b1;
        for (int i = 0; i < 20 && !last_push; i++) step(1);
        t_valid = 1'b0;
        drain();
        check("drain_out", n_out, 21);

        // Steady count=2 with simultaneous push/pop across pointer wrap
        i_ready = 1'b0;
        send(8'hA0);
        send(8'hA1);
        i_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            t_valid = 1'b1;
            t_data  = 8'hB0 + DW'(v);
            step(1);
            check("steady_count", 32'(count), 2);
        end
        t_valid = 1'b0;
        drain();
        check("wrap_out", n_out, 35);

        // Mid-stream reset
        i_ready = 1'b0;
        send(8'h61);
        send(8'h62);
        send(8'h63);
        check("pre_rst_count", 32'(count), 3);
        rstf = 1'b0;
        #2;
        check("async_count", 32'(count), 0);
        check("async_ivalid", 32'(i_valid), 0);
        step(1);
        rstf = 1'b1;
        step(1);
        watch_first = 1'b1;
        i_ready = 1'b1;
        send(8'h77);
        drain();
        check("first_after_rst", 32'(got_first), 1);
        check("first_after_rst_data", 32'(first_out), 8'h77);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eb_fifo.md
Name: eb_fifo

Overview:
- Parametrised N-entry elastic buffer; the successor to the single-entry elastic stage.
- Sits between any two valid/ready stages and absorbs up to DEPTH beats of backpressure.
- Full throughput: one beat in and one beat out per cycle.
- Exports occupancy for flow-control monitoring.
- Unlike the single-entry stage, t_ready is fully registered, with no combinational path from i_ready. This lets the block break ready-timing paths.

Parameters:
- DWIDTH, 32, payload width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2, any integer; power of two is not required).
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rstf  input  1  asynchronous active-low reset.
- t_data  input  DWIDTH  upstream payload.
- t_valid  input  1  upstream beat valid.
- t_ready  output  1  buffer can accept a beat this cycle.
- i_data  output  DWIDTH  downstream payload (head entry).
- i_valid  output  1  head entry valid.
- i_ready  input  1  downstream accepts head entry.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rstf low, async assert, sync release):
  - Write pointer, read pointer and count = 0.
  - All storage entries = 0.
  - i_valid = 0, i_data = 0, t_ready = 1 (as soon as reset is applied).
- push = t_valid & t_ready.
- pop = i_valid & i_ready.
- t_ready = (count != DEPTH). Decoded from registered count only; no combinational dependence on i_ready or t_valid.
- i_valid = (count != 0). i_data = storage[rd_ptr]. Both are pure functions of registered state.
- On push:
  - storage[wr_ptr] <= t_data.
  - wr_ptr increments, wrapping from DEPTH-1 to 0.
- On pop:
  - rd_ptr increments, wrapping from DEPTH-1 to 0.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Latency: a beat pushed in cycle n appears on i_valid/i_data in cycle n+1 at the earliest.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Full (count == DEPTH):
  - t_ready = 0, so no push occurs.
  - A pop in the same cycle frees one entry; t_ready rises the next cycle. Throughput therefore loses one cycle when full, which is accepted in exchange for registered ready.
- Empty (count == 0):
  - i_valid = 0; i_ready is ignored.
  - A push makes i_valid = 1 the next cycle.
- Push and pop in the same cycle at 0 < count < DEPTH: both proceed and count holds. Pointers may be equal only when count is 0 or DEPTH.
- Stability: while i_valid & ~i_ready, i_data and i_valid must hold next cycle.
- Reset asserted mid-stream: all contents are discarded immediately and nothing is output afterwards.
- Protocol input checks (not enforced by RTL): t_valid must not drop while ~t_ready, and t_data must be held likewise.

Optional Feature:
- Macro: EB_FIFO_BYPASS_EN.
- When defined (zero-latency cut-through):
  - When count == 0 and t_valid:
    - i_valid = 1 and i_data = t_data combinationally.
    - If i_ready is also high, the beat passes through without being written, and pointers and count are unchanged.
  - When count == 0 and t_valid & ~i_ready: the beat is stored normally.
  - i_valid = (count != 0) | t_valid.
  - t_ready remains registered, as above.
- When not defined:
  - Minimum latency is 1 cycle.
  - i_valid and i_data are register-only, exactly as above.

Test Plan (DWIDTH=8, DEPTH=4):
- Reset check: hold rstf=0 with t_valid=1 and t_data=8'hAA -> i_valid=0, i_data=0, t_ready=1, count=0. After release, no beat has been captured during reset.
- Streaming: send 8'h01..8'h10 with i_ready=1 continuously -> outputs appear in order, one per cycle, and count stays 1 after the first cycle. Without bypass, first i_valid is 1 cycle after first push; with EB_FIFO_BYPASS_EN, 8'h01 appears the same cycle and count stays 0.
- Fill to full: i_ready=0, push 8'h11,8'h22,8'h33,8'h44 -> count=4, t_ready=0, i_data=8'h11 held stable. A fifth beat 8'h55 is stalled, not lost.
- Drain from full: continue from the previous scenario, set i_ready=1 -> order 11,22,33,44,55. t_ready returns to 1 one cycle after the first pop. count never exceeds 4 or wraps.
- Simultaneous push/pop with pointer wrap: alternate one-beat bursts over more than 10 beats with count=2 steady -> count constant, data correct across rd_ptr/wr_ptr wrap 3->0.
- Mid-stream reset: count=3, assert rstf for 1 cycle -> count=0 and i_valid=0 immediately. After release, subsequent beat 8'h77 is the first output.
